pc_fetch_ctrl: RTL

Program-counter and instruction-fetch controller sitting between instruction memory and decode. It consumes the branch resolution (`branch_taken`, `branch_pc`) produced by the execute-stage branch unit and redirects fetch. It issues sequential fetch requests with credit-based flow control and buffers in-order responses in a small FIFO. On a redirect it squashes everything fetched down the wrong path.

---
 rtl/pc_fetch_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC generation, credit-limited imem fetch, in-order response FIFO.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects into a sticky HALT.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned INSTR_BYTES = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        fetch_fault
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1
`ifdef FETCH_ALIGN_CHECK_EN
        , HALT = 2'd2
`endif
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [CW-1:0]  drop_q, drop_d;
    logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  aq_rd_q, aq_rd_d;
    logic [AW-1:0]  aq_wr_q, aq_wr_d;
    logic [31:0]    aq_mem    [FIFO_DEPTH];
    logic [31:0]    pc_mem    [FIFO_DEPTH];
    logic [31:0]    instr_mem [FIFO_DEPTH];

    logic redirect, req_fire, rsp_drop, push, pop, bad_target;

    // Credits cover both in-flight requests and buffered words, so the FIFO never overflows.
    assign imem_req_valid = (state_q == RUN) &&
                            (({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < DEPTH);
    assign imem_req_addr  = fetch_pc_q;
    assign if_valid       = (fifo_cnt_q != '0);
    assign if_pc          = if_valid ? pc_mem[rd_ptr_q] : '0;
    assign if_instr       = if_valid ? instr_mem[rd_ptr_q] : '0;

    always_comb begin
        redirect   = branch_taken && (state_q == RUN);
        req_fire   = imem_req_valid && imem_req_ready;
        rsp_drop   = (drop_q != '0);
        push       = imem_rsp_valid && !rsp_drop && !redirect;
        pop        = if_valid && if_ready;
`ifdef FETCH_ALIGN_CHECK_EN
        bad_target = redirect && (branch_pc[1:0] != 2'b00);
`else
        bad_target = 1'b0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_d     = drop_q;
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        aq_rd_d    = aq_rd_q + AW'(imem_rsp_valid);
        aq_wr_d    = aq_wr_q + AW'(req_fire);
        if (imem_rsp_valid && rsp_drop) drop_d = drop_q - CW'(1);
        if (req_fire) fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
        unique case (state_q)
            BOOT:    state_d = RUN;
`ifdef FETCH_ALIGN_CHECK_EN
            RUN:     if (bad_target) state_d = HALT;
`endif
            default: state_d = state_q;
        endcase
        // Everything still in flight at redirect time belongs to the wrong path.
        if (redirect) begin
            fetch_pc_d = branch_pc;
            fifo_cnt_d = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_d     = inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            fifo_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            aq_rd_q    <= '0;
            aq_wr_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            fifo_cnt_q <= fifo_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            aq_rd_q    <= aq_rd_d;
            aq_wr_q    <= aq_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) aq_mem[aq_wr_q] <= fetch_pc_q;
        if (push) begin
            pc_mem[wr_ptr_q]    <= aq_mem[aq_rd_q];
            instr_mem[wr_ptr_q] <= imem_rsp_data;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_q | bad_target;
    end

    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && fifo_cnt_q == CW'(FIFO_DEPTH)))
                else $error("pc_fetch_ctrl: push into full response fifo");
        end
    end
`endif

endmodule
